// File: rtl/hazard_tracker_pkg.sv
// rtl/hazard_tracker_pkg.sv - shared widths, result-class codes, stage layouts and stall helper
package hazard_tracker_pkg;

  localparam int AW = 5;
  localparam int RW = 3;
  localparam int TW = 2;

  localparam logic [RW-1:0] RES_NW    = 3'd0;
  localparam logic [RW-1:0] RES_ALU   = 3'd1;
  localparam logic [RW-1:0] RES_DM    = 3'd2;
  localparam logic [RW-1:0] RES_PC    = 3'd3;
  localparam logic [RW-1:0] RES_OTHER = 3'd4;

  localparam logic [TW-1:0] TUSE_UNUSED = 2'd3;

  typedef struct packed {
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [RW-1:0] res;
    logic [TW-1:0] tnew;
  } e_stage_t;

  typedef struct packed {
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [RW-1:0] res;
    logic [TW-1:0] tnew;
  } m_stage_t;

  typedef struct packed {
    logic [AW-1:0] a3;
    logic [RW-1:0] res;
  } w_stage_t;

  // The bubble doubles as the reset value of every stage.
  localparam e_stage_t E_BUBBLE = '{a1: '0, a2: '0, a3: '0, res: RES_NW, tnew: '0};
  localparam m_stage_t M_RESET  = '{a2: '0, a3: '0, res: RES_NW, tnew: '0};
  localparam w_stage_t W_RESET  = '{a3: '0, res: RES_NW};

  // An operand stalls when an in-flight producer of it will not have its result by Tuse.
  function automatic logic operand_stall(
    input logic [AW-1:0] addr,
    input logic [TW-1:0] tuse,
    input e_stage_t      e,
    input m_stage_t      m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (addr == e.a3) && (e.res != RES_NW) && (e.tnew > tuse);
    hit_m = (addr == m.a3) && (m.res != RES_NW) && (m.tnew > tuse);
    return (addr != '0) && (tuse != TUSE_UNUSED) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// rtl/hazard_tracker_if.sv - D-stage inputs and forwarding buses of the hazard tracker
interface hazard_tracker_if;
  import hazard_tracker_pkg::*;

  logic [AW-1:0] a1_d;
  logic [AW-1:0] a2_d;
  logic [AW-1:0] a3_d;
  logic [RW-1:0] res_d;
  logic [TW-1:0] tnew_d;
  logic [TW-1:0] tuse_rs;
  logic [TW-1:0] tuse_rt;
  logic [39:0]   abus;
  logic [8:0]    resbus;
  logic          stall;

  modport master (
    output a1_d, a2_d, a3_d, res_d, tnew_d, tuse_rs, tuse_rt,
    input  abus, resbus, stall
  );

  modport slave (
    input  a1_d, a2_d, a3_d, res_d, tnew_d, tuse_rs, tuse_rt,
    output abus, resbus, stall
  );

endinterface

// File: rtl/hazard_tracker_stage_reg.sv
// rtl/hazard_tracker_stage_reg.sv - width-parameterised pipeline register with async active-low clear
module hazard_stage_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q <= RST_VAL;
    else         q <= d;
  end

endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - tracks E/M/W destinations and Tnew, packs forwarding buses, raises D stall
module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  hazard_tracker_if.slave  hif
);

  e_stage_t e_q, e_d;
  m_stage_t m_q, m_d;
  w_stage_t w_q, w_d;
  logic     stall_rs, stall_rt, stall;

  always_comb begin
    stall_rs = operand_stall(hif.a1_d, hif.tuse_rs, e_q, m_q);
    stall_rt = operand_stall(hif.a2_d, hif.tuse_rt, e_q, m_q);
    stall    = stall_rs | stall_rt;
  end

  always_comb begin
    e_d = E_BUBBLE;
    if (!stall) begin
      e_d.a1   = hif.a1_d;
      e_d.a2   = hif.a2_d;
      e_d.tnew = hif.tnew_d;
      // A $0 writer or a non-writer never shows up as a producer downstream.
      if ((hif.a3_d != '0) && (hif.res_d != RES_NW)) begin
        e_d.a3  = hif.a3_d;
        e_d.res = hif.res_d;
      end
    end

    m_d.a2   = e_q.a2;
    m_d.a3   = e_q.a3;
    m_d.res  = e_q.res;
    m_d.tnew = (e_q.tnew == '0) ? '0 : e_q.tnew - 1'b1;

    w_d.a3   = m_q.a3;
    w_d.res  = m_q.res;
  end

  hazard_stage_reg #(.W($bits(e_stage_t)), .RST_VAL(E_BUBBLE)) u_e_reg (
    .clk(clk), .resetn(reset), .d(e_d), .q(e_q)
  );

  hazard_stage_reg #(.W($bits(m_stage_t)), .RST_VAL(M_RESET)) u_m_reg (
    .clk(clk), .resetn(reset), .d(m_d), .q(m_q)
  );

  hazard_stage_reg #(.W($bits(w_stage_t)), .RST_VAL(W_RESET)) u_w_reg (
    .clk(clk), .resetn(reset), .d(w_d), .q(w_q)
  );

  assign hif.abus   = {w_q.a3, m_q.a3, e_q.a3, m_q.a2, e_q.a2, e_q.a1, hif.a2_d, hif.a1_d};
  assign hif.resbus = {w_q.res, m_q.res, e_q.res};
  assign hif.stall  = stall;

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - scoreboard bench for hazard_tracker
module tb_hazard_tracker;
  import hazard_tracker_pkg::*;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    logic [2:0] res;
  } e_view_t;

  logic    clk = 1'b0;
  logic    reset;
  int      n_pass = 0;
  int      n_total = 0;
  e_view_t exp_q[$];
  e_view_t got, want;

  hazard_tracker_if hif();

  hazard_tracker dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic [2:0] res, input logic [1:0] tnew,
                       input logic [1:0] trs, input logic [1:0] trt);
    hif.a1_d    = a1;
    hif.a2_d    = a2;
    hif.a3_d    = a3;
    hif.res_d   = res;
    hif.tnew_d  = tnew;
    hif.tuse_rs = trs;
    hif.tuse_rt = trt;
    #1;
  endtask

  // Push what E must hold after this edge, clock, then pop it against what E shows.
  task automatic advance(input logic bubble, output e_view_t g, output e_view_t w);
    e_view_t x;
    if (bubble) begin
      x = '{a1: 5'd0, a2: 5'd0, a3: 5'd0, res: RES_NW};
    end else begin
      x.a1 = hif.a1_d;
      x.a2 = hif.a2_d;
      if (hif.a3_d == 5'd0 || hif.res_d == RES_NW) begin
        x.a3  = 5'd0;
        x.res = RES_NW;
      end else begin
        x.a3  = hif.a3_d;
        x.res = hif.res_d;
      end
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    g = {hif.abus[14:10], hif.abus[19:15], hif.abus[29:25], hif.resbus[2:0]};
    w = exp_q.pop_front();
  endtask

  task automatic flush(input int n);
    e_view_t g, w;
    set_d(0, 0, 0, RES_NW, 0, TUSE_UNUSED, TUSE_UNUSED);
    for (int i = 0; i < n; i++) advance(1'b0, g, w);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_d(7, 9, 0, RES_NW, 0, TUSE_UNUSED, TUSE_UNUSED);
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (hif.abus !== 40'h0000000127) $display("FAIL reset_abus got=%h want=%h", hif.abus, 40'h0000000127);
    else n_pass++;
    n_total++;
    if (hif.resbus !== 9'd0) $display("FAIL reset_resbus got=%h want=%h", hif.resbus, 9'd0);
    else n_pass++;
    n_total++;
    if (hif.stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", hif.stall);
    else n_pass++;
    reset = 1'b1;
    set_d(0, 0, 0, RES_NW, 0, TUSE_UNUSED, TUSE_UNUSED);
    n_total++;
    if (hif.stall !== 1'b0) $display("FAIL release_stall got=%b want=0", hif.stall);
    else n_pass++;
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL release_e got=%h want=%h", got, want);
    else n_pass++;
  endtask

  task automatic test_alu_back_to_back();
    set_d(0, 0, 8, RES_ALU, 1, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    n_total++;
    if (got !== want || hif.abus[29:25] !== 5'd8 || hif.resbus[2:0] !== RES_ALU)
      $display("FAIL alu_producer_e got=%h want=%h", got, want);
    else n_pass++;
    set_d(8, 0, 9, RES_ALU, 1, 1, TUSE_UNUSED);
    n_total++;
    if (hif.stall !== 1'b0) $display("FAIL alu_consumer_stall got=%b want=0", hif.stall);
    else n_pass++;
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL alu_consumer_e got=%h want=%h", got, want);
    else n_pass++;
    n_total++;
    if (hif.abus[34:30] !== 5'd8 || hif.resbus[5:3] !== RES_ALU)
      $display("FAIL alu_producer_m got=%h/%h want=08/1", hif.abus[34:30], hif.resbus[5:3]);
    else n_pass++;
    flush(3);
  endtask

  task automatic test_load_use();
    set_d(0, 0, 8, RES_DM, 2, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL load_e got=%h want=%h", got, want);
    else n_pass++;
    set_d(8, 0, 10, RES_ALU, 1, 0, TUSE_UNUSED);
    n_total++;
    if (hif.stall !== 1'b1) $display("FAIL load_use_stall_e got=%b want=1", hif.stall);
    else n_pass++;
    advance(1'b1, got, want);
    n_total++;
    if (got !== want) $display("FAIL load_bubble1 got=%h want=%h", got, want);
    else n_pass++;
    n_total++;
    if (hif.stall !== 1'b1 || hif.abus[34:30] !== 5'd8)
      $display("FAIL load_use_stall_m got=%b/%h want=1/08", hif.stall, hif.abus[34:30]);
    else n_pass++;
    advance(1'b1, got, want);
    n_total++;
    if (got !== want) $display("FAIL load_bubble2 got=%h want=%h", got, want);
    else n_pass++;
    n_total++;
    if (hif.stall !== 1'b0) $display("FAIL load_use_release got=%b want=0", hif.stall);
    else n_pass++;
    n_total++;
    if (hif.abus[39:35] !== 5'd8 || hif.resbus[8:6] !== RES_DM)
      $display("FAIL load_w got=%h/%h want=08/2", hif.abus[39:35], hif.resbus[8:6]);
    else n_pass++;
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL load_consumer_e got=%h want=%h", got, want);
    else n_pass++;
    flush(3);
  endtask

  task automatic test_zero_unused();
    set_d(0, 0, 0, RES_ALU, 1, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL zero_writer_e got=%h want=%h", got, want);
    else n_pass++;
    set_d(0, 0, 12, RES_NW, 2, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL nw_writer_e got=%h want=%h", got, want);
    else n_pass++;
    set_d(0, 0, 12, RES_DM, 2, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL producer12_e got=%h want=%h", got, want);
    else n_pass++;
    set_d(12, 0, 0, RES_NW, 0, TUSE_UNUSED, TUSE_UNUSED);
    n_total++;
    if (hif.stall !== 1'b0) $display("FAIL unused_rs_stall got=%b want=0", hif.stall);
    else n_pass++;
    set_d(12, 0, 0, RES_NW, 0, 0, TUSE_UNUSED);
    n_total++;
    if (hif.stall !== 1'b1) $display("FAIL used_rs_stall got=%b want=1", hif.stall);
    else n_pass++;
    set_d(0, 12, 0, RES_NW, 0, 0, TUSE_UNUSED);
    n_total++;
    if (hif.stall !== 1'b0) $display("FAIL unused_rt_stall got=%b want=0", hif.stall);
    else n_pass++;
    set_d(0, 12, 0, RES_NW, 0, TUSE_UNUSED, 1);
    n_total++;
    if (hif.stall !== 1'b1) $display("FAIL used_rt_stall got=%b want=1", hif.stall);
    else n_pass++;
    flush(3);
  endtask

  task automatic test_dual_match();
    set_d(0, 0, 5, RES_ALU, 0, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    set_d(0, 0, 5, RES_PC, 0, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    n_total++;
    if (got !== want || hif.abus[34:30] !== 5'd5)
      $display("FAIL dual_setup got=%h want=%h", got, want);
    else n_pass++;
    set_d(0, 5, 0, RES_NW, 0, TUSE_UNUSED, 0);
    n_total++;
    if (hif.stall !== 1'b0) $display("FAIL dual_stall got=%b want=0", hif.stall);
    else n_pass++;
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL dual_consumer_e got=%h want=%h", got, want);
    else n_pass++;
    n_total++;
    if (hif.abus[39:35] !== 5'd5 || hif.resbus[8:6] !== RES_ALU || hif.resbus[5:3] !== RES_PC)
      $display("FAIL dual_w got=%h/%h want=05/1", hif.abus[39:35], hif.resbus[8:6]);
    else n_pass++;
    set_d(0, 0, 0, RES_NW, 0, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    n_total++;
    if (hif.abus[24:20] !== 5'd5) $display("FAIL dual_a2_m got=%h want=05", hif.abus[24:20]);
    else n_pass++;
    flush(3);
  endtask

  task automatic test_mid_stall_reset();
    set_d(0, 0, 8, RES_DM, 2, TUSE_UNUSED, TUSE_UNUSED);
    advance(1'b0, got, want);
    set_d(8, 0, 10, RES_ALU, 1, 0, TUSE_UNUSED);
    n_total++;
    if (hif.stall !== 1'b1) $display("FAIL pre_reset_stall got=%b want=1", hif.stall);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if (hif.stall !== 1'b0) $display("FAIL mid_reset_stall got=%b want=0", hif.stall);
    else n_pass++;
    n_total++;
    if (hif.abus !== 40'h0000000008 || hif.resbus !== 9'd0)
      $display("FAIL mid_reset_buses got=%h/%h want=0000000008/000", hif.abus, hif.resbus);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    advance(1'b0, got, want);
    n_total++;
    if (got !== want) $display("FAIL post_reset_e got=%h want=%h", got, want);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_zero_unused();
    test_dual_match();
    test_mid_stall_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer/tracking end of the pipeline forwarding interface.
- Captures the decoded register addresses, the result-source class and the Tnew of each instruction leaving D.
- Carries them through E, M and W, and packs them onto the 40-bit address bus and 9-bit result-class bus read by the forwarding unit.
- Computes the D-stage stall from Tuse/Tnew and inserts bubbles into E while stalled.

Parameters:
- AW, 5, register address width (fixed by bus packing; not for override)
- RW, 3, result-class code width
- TW, 2, Tuse/Tnew counter width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- a1_d  in  5  rs address of instruction in D
- a2_d  in  5  rt address of instruction in D
- a3_d  in  5  destination address of instruction in D (0 = no write)
- res_d  in  3  result class of instruction in D (`nw/`alu/`dm/`pc/`other)
- tnew_d  in  2  cycles, counted from entry to E, until the result exists
- tuse_rs  in  2  cycles from D until rs is consumed; 3 = rs unused
- tuse_rt  in  2  cycles from D until rt is consumed; 3 = rt unused
- abus  out  40  {a3_w,a3_m,a3_e,a2_m,a2_e,a1_e,a2_d,a1_d}, 5 bits each, a1_d in [4:0]
- resbus  out  9  {res_w,res_m,res_e}, res_e in [2:0]
- stall  out  1  freeze PC and the D register; E receives a bubble

Behaviour:
- Reset (reset=0, asynchronous):
  - All a*_e/m/w fields cleared to 0; all res_* cleared to `nw; tnew_e and tnew_m cleared to 0.
  - Consequences: abus = {a3_w..a1_e fields = 0, a2_d, a1_d}; resbus = 9'b0 with `nw=0; stall=0.
  - Takes effect immediately, including mid-operation; the first edge after release behaves as a normal edge.
- abus[9:0] passes a2_d/a1_d through combinationally. Every other field comes from a register.
- Stage registers on each rising edge:
  - E stage: if stall=0, E <= {a1_d, a2_d, a3_d, res_d, tnew_d}. If stall=1, E <= bubble {0,0,0,`nw,0}.
  - M stage: M <= {a2_e, a3_e, res_e}, and tnew_m <= (tnew_e==0) ? 0 : tnew_e-1.
  - W stage: W <= {a3_m, res_m}. M and W always advance; stall does not freeze them.
- Destination normalisation:
  - If a3_d==0, store res=`nw in E regardless of res_d, so a $0 writer never appears as a producer.
  - If res_d==`nw, store a3=0.
- Stall is combinational from the current state and the D inputs:
  - stall_rs = a1_d!=0 && tuse_rs!=3 && ((a1_d==a3_e && res_e!=`nw && tnew_e>tuse_rs) || (a1_d==a3_m && res_m!=`nw && tnew_m>tuse_rs))
  - stall_rt uses the same expression with a2_d and tuse_rt.
  - stall = stall_rs | stall_rt.
  - W is never a stall source: Tnew at W is 0 by definition.
- Simultaneous match in E and M: the E match governs, being the younger producer. The stall still uses OR, so either match can stall.
- A stall holds only while the condition persists. Each bubble lets tnew drain by 1, so a stall caused by an E-stage load with tnew_e=2 against tuse=0 lasts 2 cycles.
- All comparisons are unsigned, 2-bit. A tuse value of 3 disables that operand.

Decomposition:
- Result-class codes (`nw=3'd0, `alu=3'd1, `dm=3'd2, `pc=3'd3, `other=3'd4) and the Tuse "unused" code (2'd3) go in the shared head.v defines, alongside the existing fd_/falue_ codes.
- One sub-module, hazard_stage_reg: generic width-parameterised stage register with async active-low clear to a parameterised reset value. Instantiated for E, M and W.

Test Plan:
- Reset: hold reset=0 with a1_d=7, a2_d=9 → abus=40'h0000000127 (only [9:0] nonzero), resbus=0, stall=0. Release reset; no spurious stall.
- ALU back-to-back: cycle n, D={a3=8, `alu, tnew=1}; cycle n+1, D={a1=8, tuse_rs=1} → stall=0. a3_e=8 and res_e=`alu visible on abus[29:25] and resbus[2:0].
- Load-use: E={a3=8, `dm, tnew_e=2}; D={a1=8, tuse_rs=0} → stall=1 for 2 cycles. Each stalled edge loads a bubble into E (res_e=`nw). Then stall=0 and a3_m=8 with tnew_m=1 still stalls in the first cycle.
- $0 and unused operands: D={a3=0, `alu} → E holds res_e=`nw. A D instruction with a1=0, or tuse_rs=3, whose a1 matches a3_e → stall=0.
- Dual match: a3_e=a3_m=5 with tnew_e=0 and tnew_m=0, D rt=5 with tuse_rt=0 → stall=0. Pipeline advances and a3_w=5 with res_w correct after two edges.
- Mid-stall reset: assert reset while stall=1 → all stage fields clear immediately and stall drops in the same cycle.
